// File: rtl/pipelined_adder_tree.sv
// Signed binary reduction tree with optional register stages per level.
// A start flag travels with the data so start_out lines up with sum_out.
module pipelined_adder_tree #(
  parameter bit              PIPED           = 1'b1,
  parameter int              NUM_INPUTS      = 4,
  parameter int              INPUT_WIDTH     = 6,
  parameter int              LEVELS          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0,
  parameter logic [LEVELS:0] PIPE_STAGE_MASK = '1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic signed [INPUT_WIDTH-1:0]       inputs [NUM_INPUTS],
  input  logic                                start,
  output logic signed [INPUT_WIDTH+LEVELS-1:0] sum_out,
  output logic                                start_out
);

  if (NUM_INPUTS < 1) begin : g_bad_num_inputs
    $fatal(1, "pipelined_adder_tree: NUM_INPUTS must be >= 1");
  end
  if (INPUT_WIDTH < 1) begin : g_bad_input_width
    $fatal(1, "pipelined_adder_tree: INPUT_WIDTH must be >= 1");
  end
  if ((1 << LEVELS) < NUM_INPUTS) begin : g_bad_levels
    $fatal(1, "pipelined_adder_tree: LEVELS too small for NUM_INPUTS");
  end

  // Level k holds 2^(LEVELS-k) nodes of INPUT_WIDTH+k bits; level 0 is the padded operand row.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int W      = INPUT_WIDTH + k;
    localparam int N      = 1 << (LEVELS - k);
    localparam bit REG_EN = PIPED && PIPE_STAGE_MASK[k];

    logic signed [W-1:0] stage_in  [N];
    logic signed [W-1:0] stage_out [N];
    logic                valid_in;
    logic                valid_out;

    if (k == 0) begin : g_src
      always_comb begin
        for (int i = 0; i < N; i++) begin
          stage_in[i] = '0;
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
          stage_in[i] = inputs[i];
        end
        valid_in = start;
      end
    end else begin : g_add
      logic signed [W-2:0] prev [2*N];

      assign prev     = g_lvl[k-1].stage_out;
      assign valid_in = g_lvl[k-1].valid_out;

      // One bit of sign extension per level keeps every pair sum exact.
      always_comb begin
        for (int i = 0; i < N; i++) begin
          stage_in[i] = $signed({prev[2*i][W-2], prev[2*i]}) +
                        $signed({prev[2*i+1][W-2], prev[2*i+1]});
        end
      end
    end

    if (REG_EN) begin : g_reg
      // rst_n is active-high despite its name.
      always_ff @(posedge clk) begin
        if (rst_n) begin
          for (int i = 0; i < N; i++) begin
            stage_out[i] <= '0;
          end
          valid_out <= 1'b0;
        end else begin
          for (int i = 0; i < N; i++) begin
            stage_out[i] <= stage_in[i];
          end
          valid_out <= valid_in;
        end
      end
    end else begin : g_wire
      assign stage_out = stage_in;
      assign valid_out = valid_in;
    end
  end

  assign sum_out   = g_lvl[LEVELS].stage_out[0];
  assign start_out = g_lvl[LEVELS].valid_out;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Bench for pipelined_adder_tree: eight configurations share one operand pool and are
// checked every cycle against an integer-sum model delayed by each configuration's latency.
module tb_pipelined_adder_tree;

  // Per-instance operand count and expected latency (popcount of enabled stages).
  localparam int NIN [8] = '{4, 3, 4, 4, 1, 2, 5, 8};
  localparam int LAT [8] = '{3, 3, 2, 0, 1, 2, 4, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic signed [5:0] ops [8];
  logic signed [5:0] in1 [1];
  logic signed [5:0] in2 [2];
  logic signed [5:0] in3 [3];
  logic signed [5:0] in4 [4];
  logic signed [5:0] in5 [5];

  logic signed [7:0] s0, s1, s2, s3;
  logic signed [5:0] s4;
  logic signed [6:0] s5;
  logic signed [8:0] s6, s7;
  logic [7:0]        so;
  int                act [8];

  int total = 0;
  int bad = 0;
  int dl_sum [8][4];
  int dl_st  [8][4];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 1; i++) in1[i] = ops[i];
    for (int i = 0; i < 2; i++) in2[i] = ops[i];
    for (int i = 0; i < 3; i++) in3[i] = ops[i];
    for (int i = 0; i < 4; i++) in4[i] = ops[i];
    for (int i = 0; i < 5; i++) in5[i] = ops[i];
  end

  always_comb begin
    act[0] = int'(s0);
    act[1] = int'(s1);
    act[2] = int'(s2);
    act[3] = int'(s3);
    act[4] = int'(s4);
    act[5] = int'(s5);
    act[6] = int'(s6);
    act[7] = int'(s7);
  end

  pipelined_adder_tree #(.NUM_INPUTS(4), .INPUT_WIDTH(6)) u0 (
    .clk(clk), .rst_n(rst), .inputs(in4), .start(start), .sum_out(s0), .start_out(so[0]));
  pipelined_adder_tree #(.NUM_INPUTS(3), .INPUT_WIDTH(6)) u1 (
    .clk(clk), .rst_n(rst), .inputs(in3), .start(start), .sum_out(s1), .start_out(so[1]));
  pipelined_adder_tree #(.NUM_INPUTS(4), .INPUT_WIDTH(6), .PIPE_STAGE_MASK(3'b101)) u2 (
    .clk(clk), .rst_n(rst), .inputs(in4), .start(start), .sum_out(s2), .start_out(so[2]));
  pipelined_adder_tree #(.PIPED(1'b0), .NUM_INPUTS(4), .INPUT_WIDTH(6)) u3 (
    .clk(clk), .rst_n(rst), .inputs(in4), .start(start), .sum_out(s3), .start_out(so[3]));
  pipelined_adder_tree #(.NUM_INPUTS(1), .INPUT_WIDTH(6)) u4 (
    .clk(clk), .rst_n(rst), .inputs(in1), .start(start), .sum_out(s4), .start_out(so[4]));
  pipelined_adder_tree #(.NUM_INPUTS(2), .INPUT_WIDTH(6)) u5 (
    .clk(clk), .rst_n(rst), .inputs(in2), .start(start), .sum_out(s5), .start_out(so[5]));
  pipelined_adder_tree #(.NUM_INPUTS(5), .INPUT_WIDTH(6)) u6 (
    .clk(clk), .rst_n(rst), .inputs(in5), .start(start), .sum_out(s6), .start_out(so[6]));
  pipelined_adder_tree #(.NUM_INPUTS(8), .INPUT_WIDTH(6), .PIPE_STAGE_MASK(4'b1010)) u7 (
    .clk(clk), .rst_n(rst), .inputs(ops), .start(start), .sum_out(s7), .start_out(so[7]));

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(ops[i]);
    return s;
  endfunction

  // Reference: each instance is an ideal L-deep delay line of (start, exact sum).
  task automatic model_step();
    for (int d = 0; d < 8; d++) begin
      if (LAT[d] > 0) begin
        if (rst) begin
          for (int j = 0; j < LAT[d]; j++) begin
            dl_sum[d][j] = 0;
            dl_st[d][j]  = 0;
          end
        end else begin
          for (int j = LAT[d] - 1; j > 0; j--) begin
            dl_sum[d][j] = dl_sum[d][j-1];
            dl_st[d][j]  = dl_st[d][j-1];
          end
          dl_sum[d][0] = ref_sum(NIN[d]);
          dl_st[d][0]  = int'(start);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 8; d++) begin
      int es;
      int ev;
      if (LAT[d] == 0) begin
        es = ref_sum(NIN[d]);
        ev = int'(start);
      end else begin
        es = dl_sum[d][LAT[d]-1];
        ev = dl_st[d][LAT[d]-1];
      end
      check($sformatf("sum[u%0d]", d), act[d], es);
      check($sformatf("start_out[u%0d]", d), int'(so[d]), ev);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(3))
        0:       ops[i] = 6'b100000;
        1:       ops[i] = 6'b011111;
        default: ops[i] = 6'($urandom);
      endcase
    end
  endtask

  task automatic load(input int v0, input int v1, input int v2, input int v3);
    rand_ops();
    ops[0] = 6'(v0);
    ops[1] = 6'(v1);
    ops[2] = 6'(v2);
    ops[3] = 6'(v3);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ops[i] = '0;
    rst = 1'b1;
    start = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    check("reset_sum", act[0], 0);
    check("reset_start_out", int'(so[0]), 0);
    rand_ops();
    tick();
    rst = 1'b0;

    // Single pulse, L=3.
    load(10, -3, 7, -32);
    start = 1'b1;
    tick();
    start = 1'b0;
    rand_ops();
    tick();
    rand_ops();
    tick();
    check("t1_sum", act[0], -18);
    check("t1_start_out", int'(so[0]), 1);
    rand_ops();
    tick();
    check("t1_pulse_width", int'(so[0]), 0);

    // Extremes must not wrap.
    load(31, 31, 31, 31);
    start = 1'b1;
    tick();
    load(-32, -32, -32, -32);
    tick();
    start = 1'b0;
    rand_ops();
    tick();
    check("t2_max_sum", act[0], 124);
    check("t2_max_start_out", int'(so[0]), 1);
    rand_ops();
    tick();
    check("t2_min_sum", act[0], -128);
    check("t2_min_start_out", int'(so[0]), 1);

    // Back-to-back starts.
    load(1, 1, 1, 1);
    start = 1'b1;
    tick();
    load(2, 2, 2, 2);
    tick();
    load(-1, 0, 0, 0);
    tick();
    start = 1'b0;
    check("t3_sum_a", act[0], 4);
    check("t3_start_a", int'(so[0]), 1);
    rand_ops();
    tick();
    check("t3_sum_b", act[0], 8);
    check("t3_start_b", int'(so[0]), 1);
    rand_ops();
    tick();
    check("t3_sum_c", act[0], -1);
    check("t3_start_c", int'(so[0]), 1);
    rand_ops();
    tick();
    check("t3_end", int'(so[0]), 0);

    // Padding, partial mask and fully combinational variants.
    load(5, 5, 5, 0);
    start = 1'b1;
    #1;
    check("t4_comb_sum", act[3], 15);
    check("t4_comb_start_out", int'(so[3]), 1);
    tick();
    start = 1'b0;
    rand_ops();
    tick();
    check("t4_mask101_sum", act[2], 15);
    check("t4_mask101_start_out", int'(so[2]), 1);
    rand_ops();
    tick();
    check("t4_pad_sum", act[1], 15);
    check("t4_pad_start_out", int'(so[1]), 1);

    // Reset while a pulse is in flight.
    load(3, 3, 3, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    rand_ops();
    tick();
    rst = 1'b1;
    tick();
    check("t5_rst_sum", act[0], 0);
    check("t5_rst_start_out", int'(so[0]), 0);
    rst = 1'b0;
    rand_ops();
    tick();
    tick();
    check("t5_no_pulse", int'(so[0]), 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1000; n++) begin
      rand_ops();
      start = ($urandom_range(2) != 0);
      rst = ($urandom_range(63) == 0);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    for (int n = 0; n < 5; n++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
